p405s_icu_dp_regpipe: RTL and testbench

P405S_ICU_DP_REGPIPE -- requirements
Module: p405s_icu_dp_regpipe

---
 rtl/p405s_icu_dp_regpipe.sv | 103 ++++++++++
 tb/tb_p405s_icu_dp_regpipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/p405s_icu_dp_regpipe.sv
// Elastic register pipeline: DEPTH valid/ready stages of WIDTH bits, bit 0 = MSB.
// Optional per-stage even parity with ParErr output when P405S_ICU_REGPIPE_PARITY_EN is defined.
module p405s_icu_dp_regpipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CB,
  input  logic             Reset,
  input  logic             E1,
  input  logic             Flush,
  input  logic             InVal,
  input  logic [0:WIDTH-1] D,
  output logic             InRdy,
  output logic             OutVal,
  input  logic             OutRdy,
  output logic [0:WIDTH-1] L2
`ifdef P405S_ICU_REGPIPE_PARITY_EN
  ,
  output logic             ParErr
`endif
);

  logic [0:WIDTH-1] data_q [DEPTH];
  logic [0:WIDTH-1] src    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] free;
  logic [DEPTH:0]   load;
  logic             go;

`ifdef P405S_ICU_REGPIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] src_par;
`endif

  // load[DEPTH] is the drain of the last stage, so stage k is vacated exactly when load[k+1].
  // The ready chain is resolved from the output back toward stage 0.
  always_comb begin
    load  = '0;
    free  = '0;
    InRdy = 1'b0;
    go    = E1 & ~Flush;
    load[DEPTH] = go & valid_q[DEPTH-1] & OutRdy;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      free[k] = ~valid_q[k] | load[k+1];
      load[k] = go & valid_q[k-1] & free[k];
    end
    free[0] = ~valid_q[0] | load[1];
    InRdy   = go & free[0];
    load[0] = InVal & InRdy;
  end

  always_comb begin
    src[0] = D;
    for (int k = 1; k < DEPTH; k++) begin
      src[k] = data_q[k-1];
    end
  end

`ifdef P405S_ICU_REGPIPE_PARITY_EN
  always_comb begin
    src_par    = '0;
    src_par[0] = ^D;
    for (int k = 1; k < DEPTH; k++) begin
      src_par[k] = par_q[k-1];
    end
  end
`endif

  // Loads and vacates are already gated by E1/Flush, so stages with neither simply hold.
  always_ff @(posedge CB) begin
    if (Reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
`ifdef P405S_ICU_REGPIPE_PARITY_EN
      par_q <= '0;
`endif
    end else if (Flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= src[k];
`ifdef P405S_ICU_REGPIPE_PARITY_EN
          par_q[k]   <= src_par[k];
`endif
        end else if (load[k+1]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign OutVal = valid_q[DEPTH-1];
  assign L2     = data_q[DEPTH-1];

`ifdef P405S_ICU_REGPIPE_PARITY_EN
  assign ParErr = OutVal & ((^L2) ^ par_q[DEPTH-1]);
`endif

endmodule

// File: tb/tb_p405s_icu_dp_regpipe.sv
// Bench for p405s_icu_dp_regpipe (WIDTH=32, DEPTH=2): cycle vector table, directed
// corner sequences, and an in-order scoreboard of accepted words.
module tb_p405s_icu_dp_regpipe;

  logic        CB;
  logic        Reset;
  logic        E1;
  logic        Flush;
  logic        InVal;
  logic [31:0] D;
  logic        InRdy;
  logic        OutVal;
  logic        OutRdy;
  logic [31:0] L2;
`ifdef P405S_ICU_REGPIPE_PARITY_EN
  logic        ParErr;
`endif

  int n_checks;
  int n_fail;
  logic [31:0] sbq [$];

  typedef struct {
    logic        rst;
    logic        e1;
    logic        flush;
    logic        inval;
    logic [31:0] d;
    logic        outrdy;
    logic        exp_inrdy;
    logic        exp_outval;
    logic        chk_l2;
    logic [31:0] exp_l2;
  } vec_t;

  vec_t vecs [$];

  p405s_icu_dp_regpipe #(.WIDTH(32), .DEPTH(2)) dut (
    .CB     (CB),
    .Reset  (Reset),
    .E1     (E1),
    .Flush  (Flush),
    .InVal  (InVal),
    .D      (D),
    .InRdy  (InRdy),
    .OutVal (OutVal),
    .OutRdy (OutRdy),
    .L2     (L2)
`ifdef P405S_ICU_REGPIPE_PARITY_EN
    ,
    .ParErr (ParErr)
`endif
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Uses the values the next rising edge will see: words accepted are queued, words
  // drained are compared against the oldest queued word.
  task automatic scoreboardStep();
    logic [31:0] exp;
    if (Reset || Flush) begin
      sbq.delete();
    end else begin
      if (E1 && OutVal && OutRdy) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected_word", L2, 32'hxxxxxxxx);
        end else begin
          exp = sbq.pop_front();
          checkOutput("sb_order", L2, exp);
        end
      end
      if (InVal && InRdy) sbq.push_back(D);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic e1, input logic fl,
                               input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge CB);
    Reset  = rst;
    E1     = e1;
    Flush  = fl;
    InVal  = iv;
    D      = d;
    OutRdy = ordy;
    #1;
    scoreboardStep();
  endtask

  task automatic addVec(input logic rst, input logic e1, input logic fl, input logic iv,
                        input logic [31:0] d, input logic ordy, input logic xrdy,
                        input logic xval, input logic chk, input logic [31:0] xl2);
    vec_t v;
    v.rst = rst; v.e1 = e1; v.flush = fl; v.inval = iv; v.d = d; v.outrdy = ordy;
    v.exp_inrdy = xrdy; v.exp_outval = xval; v.chk_l2 = chk; v.exp_l2 = xl2;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1; E1 = 1'b0; Flush = 1'b0; InVal = 1'b0; D = '0; OutRdy = 1'b0;

    //      rst e1 fl iv d             ordy rdy val chk l2
    addVec(1, 1, 0, 0, 32'h0,        1,   1,  0,  1, 32'h0);
    addVec(0, 1, 0, 1, 32'h12345678, 1,   1,  0,  1, 32'h0);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  0,  1, 32'h0);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  1,  1, 32'h12345678);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  0,  0, 32'h0);
    addVec(0, 1, 0, 1, 32'hA,        0,   1,  0,  0, 32'h0);
    addVec(0, 1, 0, 1, 32'hB,        0,   1,  0,  0, 32'h0);
    addVec(0, 1, 0, 1, 32'hC,        0,   0,  1,  1, 32'hA);
    addVec(0, 1, 0, 1, 32'hC,        0,   0,  1,  1, 32'hA);
    addVec(0, 1, 0, 1, 32'hC,        1,   1,  1,  1, 32'hA);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  1,  1, 32'hB);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  1,  1, 32'hC);
    addVec(0, 1, 0, 1, 32'hA,        0,   1,  0,  0, 32'h0);
    addVec(0, 1, 0, 1, 32'hB,        0,   1,  0,  0, 32'h0);
    addVec(0, 1, 1, 1, 32'hC,        1,   0,  1,  1, 32'hA);
    addVec(0, 1, 0, 0, 32'h0,        1,   1,  0,  0, 32'h0);
    addVec(0, 0, 1, 0, 32'h0,        1,   0,  0,  0, 32'h0);

    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].e1, vecs[i].flush, vecs[i].inval, vecs[i].d, vecs[i].outrdy);
      checkOutput($sformatf("vec%0d_inrdy", i), {31'b0, InRdy}, {31'b0, vecs[i].exp_inrdy});
      checkOutput($sformatf("vec%0d_outval", i), {31'b0, OutVal}, {31'b0, vecs[i].exp_outval});
      if (vecs[i].chk_l2) checkOutput($sformatf("vec%0d_l2", i), L2, vecs[i].exp_l2);
    end

    // Back-to-back stream: one word per cycle in and out.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, i < 4, 32'(i + 1), 1);
      if (i < 4) checkOutput($sformatf("tput%0d_inrdy", i), {31'b0, InRdy}, 32'd1);
      if (i >= 2 && i < 6) begin
        checkOutput($sformatf("tput%0d_outval", i), {31'b0, OutVal}, 32'd1);
        checkOutput($sformatf("tput%0d_l2", i), L2, 32'(i - 1));
      end
      if (i == 6) checkOutput("tput_outval_end", {31'b0, OutVal}, 32'd0);
    end

    // Global enable low for three cycles mid-stream.
    applyStimulus(0, 1, 0, 1, 32'h10, 1);
    applyStimulus(0, 1, 0, 1, 32'h11, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h12, 1);
      checkOutput($sformatf("stall%0d_inrdy", i), {31'b0, InRdy}, 32'd0);
      checkOutput($sformatf("stall%0d_outval", i), {31'b0, OutVal}, 32'd1);
      checkOutput($sformatf("stall%0d_l2", i), L2, 32'h10);
    end
    applyStimulus(0, 1, 0, 1, 32'h12, 1);
    checkOutput("resume_inrdy", {31'b0, InRdy}, 32'd1);
    checkOutput("resume_l2_0", L2, 32'h10);
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    checkOutput("resume_l2_1", L2, 32'h11);
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    checkOutput("resume_l2_2", L2, 32'h12);
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    checkOutput("resume_outval_end", {31'b0, OutVal}, 32'd0);

    // Reset with words in flight discards them and clears data.
    applyStimulus(0, 1, 0, 1, 32'h20, 0);
    applyStimulus(0, 1, 0, 1, 32'h21, 0);
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    checkOutput("prerst_l2", L2, 32'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0, 1);
      checkOutput($sformatf("postrst%0d_outval", i), {31'b0, OutVal}, 32'd0);
      checkOutput($sformatf("postrst%0d_l2", i), L2, 32'h0);
    end

`ifdef P405S_ICU_REGPIPE_PARITY_EN
    applyStimulus(0, 1, 0, 1, 32'h7, 1);
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    checkOutput("par_good_l2", L2, 32'h7);
    checkOutput("par_good_err", {31'b0, ParErr}, 32'd0);
    applyStimulus(0, 1, 0, 1, 32'h1, 0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0);
    checkOutput("par_held_err", {31'b0, ParErr}, 32'd0);
    force dut.par_q = 2'b00;
    #1;
    checkOutput("par_bad_err", {31'b0, ParErr}, 32'd1);
    release dut.par_q;
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
`endif

    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0, 1);
    end
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
